// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered opcode ALU with valid/ready handshakes and a restoring divider
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MUL_K = 5,
  parameter int unsigned DIV_K = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic             zero,
  output logic             err
);

  if (WIDTH < 4) begin : g_bad_width
    $error("alu_seq: WIDTH must be at least 4");
  end
  if (DIV_K == 0 || (64'(DIV_K) >> WIDTH) != 0) begin : g_bad_div_k
    $error("alu_seq: DIV_K must be nonzero and fit in WIDTH bits");
  end
  if ((64'(MUL_K) >> WIDTH) != 0) begin : g_bad_mul_k
    $error("alu_seq: MUL_K must fit in WIDTH bits");
  end

  localparam int unsigned            CW     = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0]     MUL_KW = (2*WIDTH)'(MUL_K);
  localparam logic [WIDTH:0]         DIV_KW = (WIDTH+1)'(DIV_K);
  localparam logic [WIDTH-1:0]       ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic             accept;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             div_last;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic               alu_err;

  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] work_next;

  // armed keeps in_ready low until the first edge after reset release
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = armed;
        accept   = in_valid && armed;
        if (accept) state_nxt = (opcode == 4'd3) ? S_DIV : S_OUT;
      end
      S_DIV: begin
        if (div_last) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    prod    = {{WIDTH{1'b0}}, a} * MUL_KW;
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      4'd0: begin alu_res = sum[WIDTH-1:0]; alu_ov = sum[WIDTH]; end
      4'd1: begin alu_res = a - b; alu_ov = (a < b); end
      4'd2: begin alu_res = prod[WIDTH-1:0]; alu_ov = |prod[2*WIDTH-1:WIDTH]; end
      4'd3: begin alu_res = '0; end
      4'd4: begin alu_res = a + ONE; alu_ov = &a; end
      4'd5: begin alu_res = b - ONE; alu_ov = ~|b; end
      4'd6: alu_res = a & b;
      4'd7: alu_res = a ^ b;
      4'd8: alu_res = a | b;
      4'd9: alu_res = ~a;
      default: alu_err = 1'b1;
    endcase
  end

  // Quotient bits shift into the low end of work as dividend bits leave the top
  always_comb begin
    trial     = {rem, work[WIDTH-1]};
    q_bit     = (trial >= DIV_KW);
    rem_next  = q_bit ? WIDTH'(trial - DIV_KW) : trial[WIDTH-1:0];
    work_next = {work[WIDTH-2:0], q_bit};
    div_last  = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      ov     <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      work   <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (opcode == 4'd3) begin
              work <= a;
              rem  <= '0;
              cnt  <= '0;
            end else begin
              result <= alu_res;
              ov     <= alu_ov;
              err    <= alu_err;
              zero   <= ~|alu_res;
            end
          end
        end
        S_DIV: begin
          work <= work_next;
          rem  <= rem_next;
          cnt  <= cnt + CW'(1);
          if (div_last) begin
            result <= work_next;
            ov     <= 1'b0;
            err    <= 1'b0;
            zero   <= ~|work_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=16 and WIDTH=8
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, vo16, or16 = 1'b1, ovf16, z16, e16;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  op16 = '0;
  logic        iv8 = 1'b0, ir8, vo8, or8 = 1'b1, ovf8, z8, e8;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic [3:0]  op8 = '0;

  alu_seq #(.WIDTH(16), .MUL_K(5), .DIV_K(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .opcode(op16), .out_valid(vo16), .out_ready(or16), .result(res16),
    .ov(ovf16), .zero(z16), .err(e16));

  alu_seq #(.WIDTH(8), .MUL_K(3), .DIV_K(7)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .opcode(op8), .out_valid(vo8), .out_ready(or8), .result(res8),
    .ov(ovf8), .zero(z8), .err(e8));

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          w8;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    bit          o, z, e;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit v);
    if (w8) begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; iv8 = v; end
    else    begin op16 = op; a16 = a; b16 = b; iv16 = v; end
  endtask

  task automatic samp(input bit w8, output bit vld, output bit rdy, output logic [15:0] r,
                      output bit o, output bit z, output bit e);
    if (w8) begin vld = vo8; rdy = ir8; r = {8'h00, res8}; o = ovf8; z = z8; e = e8; end
    else    begin vld = vo16; rdy = ir16; r = res16; o = ovf16; z = z16; e = e16; end
  endtask

  // Reference model computed straight from the opcode rules with wide integers
  task automatic model(input bit w8, input logic [3:0] op, input longint a, input longint b,
                       output logic [15:0] r, output bit o, output bit z, output bit e);
    longint w, mask, mk, dk, x;
    w = w8 ? 8 : 16; mask = (64'sd1 <<< w) - 1;
    mk = w8 ? 3 : 5; dk = w8 ? 7 : 10;
    o = 1'b0; e = 1'b0; x = 0;
    case (op)
      4'd0: begin x = a + b; o = (x > mask); end
      4'd1: begin x = a - b; o = (a < b); end
      4'd2: begin x = a * mk; o = (x > mask); end
      4'd3: x = a / dk;
      4'd4: begin x = a + 1; o = (a == mask); end
      4'd5: begin x = b - 1; o = (b == 0); end
      4'd6: x = a & b;
      4'd7: x = a ^ b;
      4'd8: x = a | b;
      4'd9: x = ~a;
      default: begin x = 0; e = 1'b1; end
    endcase
    x = x & mask;
    r = x[15:0];
    z = (x == 0);
  endtask

  task automatic do_op(input bit w8, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string nm, input int exp_lat, input logic [15:0] er,
                       input bit eo, input bit ez, input bit ee);
    bit vld, rdy, o, z, e, busy_rdy;
    logic [15:0] r;
    int n, lat;
    @(negedge clk);
    samp(w8, vld, rdy, r, o, z, e);
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); samp(w8, vld, rdy, r, o, z, e); n++; end
    if (!rdy) chk({nm, " wait_ready"}, 64'(rdy), 64'd1);
    drive(w8, op, a, b, 1'b1);
    @(negedge clk);
    drive(w8, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    lat = 1; busy_rdy = 1'b0;
    samp(w8, vld, rdy, r, o, z, e);
    while (!vld && lat < 40) begin
      busy_rdy |= rdy;
      @(negedge clk); lat++;
      samp(w8, vld, rdy, r, o, z, e);
    end
    chk({nm, " latency"}, 64'(vld ? lat : -1), 64'(exp_lat));
    chk({nm, " busy_in_ready"}, 64'(busy_rdy | (vld & rdy)), 64'd0);
    chk({nm, " result"}, 64'(r), 64'(er));
    chk({nm, " ov"}, 64'(o), 64'(eo));
    chk({nm, " zero"}, 64'(z), 64'(ez));
    chk({nm, " err"}, 64'(e), 64'(ee));
  endtask

  function automatic vec_t mk(input bit w8, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input bit o, input bit z, input bit e, input int lat);
    vec_t v;
    v.w8 = w8; v.op = op; v.a = a; v.b = b; v.r = r; v.o = o; v.z = z; v.e = e; v.lat = lat;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    bit vld, rdy, o, z, e, ok_v, ok_r, ok_i, ever_v;
    logic [15:0] r, ra, rb, mr;
    logic [3:0] rop;
    bit mo, mz, me;

    vt.push_back(mk(0, 4'd0, 16'hFFFF, 16'd2,     16'd1,     1, 0, 0, 1));
    vt.push_back(mk(0, 4'd0, 16'hFFFF, 16'd1,     16'd0,     1, 1, 0, 1));
    vt.push_back(mk(0, 4'd9, 16'h00FF, 16'd0,     16'hFF00,  0, 0, 0, 1));
    vt.push_back(mk(0, 4'd2, 16'd13107, 16'd0,    16'd65535, 0, 0, 0, 1));
    vt.push_back(mk(0, 4'd2, 16'd13108, 16'd0,    16'd4,     1, 0, 0, 1));
    vt.push_back(mk(0, 4'd4, 16'hFFFF, 16'd0,     16'd0,     1, 1, 0, 1));
    vt.push_back(mk(0, 4'd5, 16'h1234, 16'd0,     16'hFFFF,  1, 0, 0, 1));
    vt.push_back(mk(0, 4'd3, 16'd12345, 16'd0,    16'd1234,  0, 0, 0, 17));
    vt.push_back(mk(0, 4'd3, 16'd9, 16'd0,        16'd0,     0, 1, 0, 17));
    vt.push_back(mk(0, 4'd12, 16'h5A5A, 16'h1111, 16'd0,     0, 1, 1, 1));
    vt.push_back(mk(0, 4'd6, 16'hF0F0, 16'h0FF0,  16'h00F0,  0, 0, 0, 1));
    vt.push_back(mk(0, 4'd8, 16'hF000, 16'h000F,  16'hF00F,  0, 0, 0, 1));
    vt.push_back(mk(0, 4'd1, 16'd3, 16'd5,        16'hFFFE,  1, 0, 0, 1));
    vt.push_back(mk(1, 4'd3, 16'd200, 16'd0,      16'd28,    0, 0, 0, 9));
    vt.push_back(mk(1, 4'd2, 16'd86, 16'd0,       16'd2,     1, 0, 0, 1));
    vt.push_back(mk(1, 4'd0, 16'hFF, 16'd1,       16'd0,     1, 1, 0, 1));
    vt.push_back(mk(1, 4'd1, 16'd3, 16'd5,        16'hFE,    1, 0, 0, 1));
    vt.push_back(mk(1, 4'd4, 16'hFF, 16'd0,       16'd0,     1, 1, 0, 1));
    vt.push_back(mk(1, 4'd5, 16'd0, 16'd0,        16'hFF,    1, 0, 0, 1));
    vt.push_back(mk(1, 4'd3, 16'd6, 16'd0,        16'd0,     0, 1, 0, 9));
    vt.push_back(mk(1, 4'd15, 16'd7, 16'd7,       16'd0,     0, 1, 1, 1));

    // Reset values while rst_n is held low
    #1;
    chk("rst out_valid16", 64'(vo16), 64'd0);
    chk("rst in_ready16", 64'(ir16), 64'd0);
    chk("rst result16", 64'(res16), 64'd0);
    chk("rst flags16", 64'({ovf16, z16, e16}), 64'd0);
    chk("rst in_ready8", 64'(ir8), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release in_ready before edge", 64'(ir16), 64'd0);
    @(negedge clk);
    chk("release in_ready after edge", 64'(ir16), 64'd1);
    chk("release out_valid", 64'(vo16), 64'd0);

    foreach (vt[i])
      do_op(vt[i].w8, vt[i].op, vt[i].a, vt[i].b, $sformatf("vec%0d", i),
            vt[i].lat, vt[i].r, vt[i].o, vt[i].z, vt[i].e);

    // Backpressure: result held while the consumer stalls, requests ignored
    @(negedge clk);
    while (!ir16) @(negedge clk);
    or16 = 1'b0;
    drive(0, 4'd7, 16'hAAAA, 16'hFFFF, 1'b1);
    @(negedge clk);
    ok_v = 1'b1; ok_r = 1'b1; ok_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      samp(0, vld, rdy, r, o, z, e);
      ok_v &= vld; ok_r &= (r == 16'h5555); ok_i &= !rdy;
      drive(0, 4'd0, 16'($urandom), 16'($urandom), i[0]);
      @(negedge clk);
    end
    chk("bp out_valid held", 64'(ok_v), 64'd1);
    chk("bp result held", 64'(ok_r), 64'd1);
    chk("bp in_ready low", 64'(ok_i), 64'd1);
    iv16 = 1'b0; or16 = 1'b1;
    @(negedge clk);
    chk("bp handoff out_valid", 64'(vo16), 64'd0);
    chk("bp handoff in_ready", 64'(ir16), 64'd1);
    @(negedge clk);
    chk("bp no ghost accept", 64'(vo16), 64'd0);

    // Reset in the middle of a divide
    while (!ir16) @(negedge clk);
    drive(0, 4'd3, 16'd1000, 16'd0, 1'b1);
    @(negedge clk);
    iv16 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(vo16), 64'd0);
    chk("abort in_ready", 64'(ir16), 64'd0);
    chk("abort result", 64'(res16), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort release in_ready", 64'(ir16), 64'd0);
    ever_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ever_v |= vo16;
    end
    chk("abort no output", 64'(ever_v), 64'd0);
    chk("abort result after", 64'(res16), 64'd0);
    chk("abort in_ready after", 64'(ir16), 64'd1);
    do_op(0, 4'd1, 16'd3, 16'd5, "post_abort sub", 1, 16'hFFFE, 1, 0, 0);

    // Randomized operations against the reference model
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 40; i++) begin
        rop = 4'($urandom_range(0, 15));
        ra = 16'($urandom); rb = 16'($urandom);
        if (w == 1) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
        if (i % 10 == 0) ra = (w == 1) ? 16'h00FF : 16'hFFFF;
        model(w[0], rop, longint'(ra), longint'(rb), mr, mo, mz, me);
        do_op(w[0], rop, ra, rb, $sformatf("rnd w%0d i%0d op%0d", w, i, rop),
              (rop == 4'd3) ? ((w == 1) ? 9 : 17) : 1, mr, mo, mz, me);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit opcode ALU.
- Keeps the same ten-operation opcode map and adds real carry/borrow overflow, zero and error flags.
- Adds valid/ready handshakes on input and output, and a multi-cycle restoring divider.
- Sits between an operand/opcode source and a result consumer; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 4).
- MUL_K, 5, unsigned constant multiplier for opcode 2; must fit in WIDTH bits.
- DIV_K, 10, unsigned constant divisor for opcode 3; must be nonzero and fit in WIDTH bits (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  4  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- ov  out  1  unsigned overflow/borrow.
- zero  out  1  result equals 0.
- err  out  1  illegal opcode.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, ov=0, zero=0, err=0, out_valid=0, in_ready=0 while rst_n low. Any in-progress divide is discarded. in_ready=1 from the first clock edge after release.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - DIV: in_ready=0, out_valid=0, divider iterating.
  - OUT: in_ready=0, out_valid=1, result/flags held stable.
- Accept occurs on in_valid && in_ready at a rising edge; a, b and opcode are captured that cycle.
- Accept of any opcode except 3 → OUT on the next edge (latency 1).
- Accept of opcode 3 → DIV, then exactly WIDTH edges later → OUT (latency WIDTH+1).
- OUT with out_ready=1 → IDLE on that edge. out_valid and data hold while out_ready=0, with no timeout.
- No new request is accepted in the same cycle as an output handoff; throughput is at most one op per 2 cycles.
- Opcode map (all arithmetic unsigned, result truncated to WIDTH):
  - 0: a+b; ov = carry out.
  - 1: a-b; ov = (a<b).
  - 2: a*MUL_K using a 2*WIDTH product; result = low half; ov = (high half != 0).
  - 3: a/DIV_K via restoring division, 1 quotient bit per cycle, MSB first; ov=0.
  - 4: a+1; ov = (a == all-ones), result wraps to 0.
  - 5: b-1; ov = (b == 0), result wraps to all-ones.
  - 6: a&b; ov=0.
  - 7: a^b; ov=0.
  - 8: a|b; ov=0.
  - 9: ~a; ov=0.
  - 10-15: result=0, ov=0, err=1.
- err=0 for all legal opcodes. zero = (result==0) for every opcode, including illegal ones (zero=1, err=1).
- Flags are registered with result and change only on entry to OUT.
- Inputs a, b and opcode may change freely after accept without affecting the op in flight.
- Async reset during DIV or OUT aborts immediately. No result is emitted for the aborted request.

Test Plan:
- Reset mid-divide: accept op3 a=1000, deassert rst_n after 5 cycles, release → out_valid stays 0; result=0; in_ready=1 after the first edge post-release; next op1 a=3,b=5 → result=16'hFFFE, ov=1.
- Single-cycle ops, WIDTH=16: op0 a=16'hFFFF,b=2 → result=1, ov=1, zero=0, out_valid one cycle after accept; op0 a=16'hFFFF,b=1 → result=0, ov=1, zero=1; op9 a=16'h00FF → 16'hFF00.
- Multiply and increment/decrement edges: op2 a=13107 → result=65535, ov=0; op2 a=13108 → result=4, ov=1; op4 a=16'hFFFF → result=0, ov=1, zero=1; op5 b=0 → result=16'hFFFF, ov=1.
- Divider latency: op3 a=12345 → out_valid exactly 17 cycles after accept, result=1234; op3 a=9 → result=0, zero=1, ov=0; in_ready=0 throughout DIV.
- Output backpressure: op7 a=16'hAAAA,b=16'hFFFF with out_ready=0 for 10 cycles → result=16'h5555 held stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next edge.
- Illegal opcode and parametrisation: op12 → result=0, err=1, zero=1. Rerun all cases with WIDTH=8, MUL_K=3, DIV_K=7: op3 a=200 → result=28 at latency 9; op2 a=86 → result=2, ov=1.
